// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the L2 main-memory controller.
package mem_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 17;
  localparam int unsigned DEF_LATENCY    = 4;
  localparam int unsigned DEF_IDX_W      = DEF_ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    DONE,
    DRAIN
  } memctrl_state_t;

  // Latched writeback; doubles as the posted write buffer when buffering is built in.
  // The address is kept as a word index, sized for the default configuration.
  typedef struct packed {
    logic                      valid;
    logic [DEF_IDX_W-1:0]      addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wbuf_t;

endpackage

// File: rtl/l2_mem_ctrl_if.sv
// L2 <-> memory controller request/fill bus.
interface l2_mem_ctrl_if #(
  parameter int unsigned DATA_WIDTH = mem_ctrl_pkg::DEF_DATA_WIDTH
);
  logic                  fetch;
  logic [DATA_WIDTH-1:0] A;
  logic                  writeback;
  logic [DATA_WIDTH-1:0] WB_addr;
  logic [DATA_WIDTH-1:0] WB_DATA;
  logic [DATA_WIDTH-1:0] RD;
  logic                  fill_valid;
  logic                  busy;

  modport master (
    output fetch, A, writeback, WB_addr, WB_DATA,
    input  RD, fill_valid, busy
  );

  modport slave (
    input  fetch, A, writeback, WB_addr, WB_DATA,
    output RD, fill_valid, busy
  );
endinterface

// File: rtl/main_memory.sv
// Word-addressed backing array: synchronous write, registered read, no reset.
module main_memory
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IDX_W      = DEF_IDX_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/l2_mem_ctrl.sv
// L2 main-memory controller: serialises fetch/writeback into fixed-latency
// accesses on main_memory. Optional posted write buffer: L2_MEM_CTRL_WBUF_EN.
module l2_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LATENCY    = DEF_LATENCY
) (
  input logic          clk,
  input logic          rst,
  l2_mem_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  memctrl_state_t        state;
  logic [CNT_W-1:0]      cnt;
  logic                  fetch_q;
  logic [IDX_W-1:0]      a_idx_q;
  wbuf_t                 wb_q;
  logic                  fill_valid_q;
  logic                  rd_ok_q;
  logic                  phase_last;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [IDX_W-1:0]      a_idx;
  logic [IDX_W-1:0]      wb_idx;
  logic                  unused_addr_bits;
`ifdef L2_MEM_CTRL_WBUF_EN
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
`endif

  // Word index decode; byte-offset and out-of-range bits are don't-care.
  assign a_idx  = bus.A[ADDR_WIDTH-1:2];
  assign wb_idx = bus.WB_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{bus.A[1:0], bus.A[DATA_WIDTH-1:ADDR_WIDTH],
                              bus.WB_addr[1:0], bus.WB_addr[DATA_WIDTH-1:ADDR_WIDTH]};

  // Memory strobes fire on the last cycle of a phase; suppressed under reset.
  assign phase_last = (cnt == '0);
  assign mem_we = !rst && phase_last && wb_q.valid && ((state == WB) || (state == DRAIN));
  assign mem_re = !rst && phase_last && (state == RD);

  // Status and fill data outputs.
  assign bus.busy       = (state != IDLE);
  assign bus.fill_valid = fill_valid_q;
`ifdef L2_MEM_CTRL_WBUF_EN
  assign bus.RD = !rd_ok_q ? '0 : (fwd_q ? fwd_data_q : mem_rdata);
`else
  assign bus.RD = rd_ok_q ? mem_rdata : '0;
`endif

  // Request sequencing FSM with phase down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wb_q.valid   <= 1'b0;
      fill_valid_q <= 1'b0;
      rd_ok_q      <= 1'b0;
`ifdef L2_MEM_CTRL_WBUF_EN
      fwd_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          fill_valid_q <= 1'b0;
          if (bus.fetch || bus.writeback) begin
            fetch_q    <= bus.fetch;
            a_idx_q    <= a_idx;
            wb_q.valid <= bus.writeback;
            wb_q.addr  <= DEF_IDX_W'(wb_idx);
            wb_q.data  <= DEF_DATA_WIDTH'(bus.WB_DATA);
            cnt        <= CNT_LOAD;
`ifdef L2_MEM_CTRL_WBUF_EN
            state      <= bus.fetch ? RD : WB;
`else
            state      <= bus.writeback ? WB : RD;
`endif
          end
        end
        WB: begin
          if (phase_last) begin
            wb_q.valid <= 1'b0;
            cnt        <= CNT_LOAD;
            state      <= fetch_q ? RD : IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD: begin
          if (phase_last) begin
            state        <= DONE;
            fill_valid_q <= 1'b1;
            rd_ok_q      <= 1'b1;
`ifdef L2_MEM_CTRL_WBUF_EN
            fwd_q      <= wb_q.valid && (wb_q.addr == DEF_IDX_W'(a_idx_q));
            fwd_data_q <= DATA_WIDTH'(wb_q.data);
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          fill_valid_q <= 1'b0;
`ifdef L2_MEM_CTRL_WBUF_EN
          if (wb_q.valid) begin
            cnt   <= CNT_LOAD;
            state <= DRAIN;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        DRAIN: begin
          if (phase_last) begin
            wb_q.valid <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  main_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (IDX_W'(wb_q.addr)),
    .wdata (DATA_WIDTH'(wb_q.data)),
    .re    (mem_re),
    .raddr (a_idx_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Self-checking bench for l2_mem_ctrl against a word-level memory model.
module tb_l2_mem_ctrl;

  localparam int unsigned L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mem_m [int unsigned];
  logic [31:0] last_rd = '0;
  logic [14:0] pool [8];

  l2_mem_ctrl_if #(.DATA_WIDTH(32)) bus ();

  l2_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return int'(a[16:2]);
  endfunction

  // Issue one request from a negedge, check every cycle until idle again.
  task automatic run_req(input bit f, input logic [31:0] a, input bit w,
                         input logic [31:0] wa, input logic [31:0] wd, input bit spur);
    int unsigned busy_len;
    int unsigned fill_k;
    logic [31:0] exp_rd;
    bus.fetch = f; bus.A = a; bus.writeback = w; bus.WB_addr = wa; bus.WB_DATA = wd;
    @(posedge clk);
    #1;
    bus.fetch = 1'b0; bus.writeback = 1'b0;
    exp_rd = '0;
    if (f) begin
      if (w && widx(wa) == widx(a)) exp_rd = wd;
      else if (mem_m.exists(widx(a))) exp_rd = mem_m[widx(a)];
    end
    if (w) mem_m[widx(wa)] = wd;
    if (f && w) busy_len = 2 * L + 1;
    else if (f) busy_len = L + 1;
    else busy_len = L;
`ifdef L2_MEM_CTRL_WBUF_EN
    fill_k = f ? L + 1 : 0;
`else
    fill_k = f ? (w ? 2 * L + 1 : L + 1) : 0;
`endif
    for (int unsigned k = 1; k <= busy_len + 1; k++) begin
      @(negedge clk);
      check($sformatf("busy k=%0d", k), 32'(bus.busy), 32'(k <= busy_len));
      check($sformatf("fill_valid k=%0d", k), 32'(bus.fill_valid), 32'(k == fill_k));
      if (k == fill_k) check($sformatf("RD a=%h", a), bus.RD, exp_rd);
      if (spur && k == 2) begin
        bus.fetch = 1'b1; bus.A = 32'h44; bus.writeback = 1'b1;
        bus.WB_addr = 32'h44; bus.WB_DATA = $urandom;
      end
      if (spur && k == 3) begin
        bus.fetch = 1'b0; bus.writeback = 1'b0;
      end
    end
    if (f) last_rd = exp_rd;
    check("RD hold", bus.RD, last_rd);
  endtask

  task automatic check_idle_reset_values(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " fill_valid"}, 32'(bus.fill_valid), 32'd0);
    check({tag, " RD"}, bus.RD, 32'd0);
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v44;
    logic [31:0] a;
    logic [31:0] wa;
    int unsigned kind;

    bus.fetch = 1'b0; bus.A = '0; bus.writeback = 1'b0; bus.WB_addr = '0; bus.WB_DATA = '0;

    // Reset then idle.
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle_reset_values("in reset");
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle_reset_values("idle");
    end

    // Preload via writebacks.
    v44 = $urandom;
    v1  = $urandom;
    run_req(1'b0, '0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
    run_req(1'b0, '0, 1'b1, 32'h44, v44, 1'b0);
    run_req(1'b0, '0, 1'b1, 32'hC0, v1, 1'b0);

    // Fetch only.
    run_req(1'b1, 32'h40, 1'b0, '0, '0, 1'b0);

    // Write-then-read same address, then confirm memory contents.
    run_req(1'b1, 32'h80, 1'b1, 32'h80, 32'h12345678, 1'b0);
    run_req(1'b1, 32'h80, 1'b0, '0, '0, 1'b0);

    // Requests pulsed while busy are ignored.
    run_req(1'b1, 32'h40, 1'b0, '0, '0, 1'b1);
    run_req(1'b1, 32'h44, 1'b0, '0, '0, 1'b0);

    // Reset during cycle 2 of a writeback drops the write.
    bus.writeback = 1'b1; bus.WB_addr = 32'hC0; bus.WB_DATA = ~v1;
    @(posedge clk);
    #1;
    bus.writeback = 1'b0;
    @(negedge clk);
    check("busy WB c1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset_values("after mid-WB reset");
    rst = 1'b0;
    last_rd = '0;
    run_req(1'b1, 32'hC0, 1'b0, '0, '0, 1'b0);

    // Address wrap modulo 2^17.
    run_req(1'b1, 32'h20040, 1'b0, '0, '0, 1'b0);

    // Randomised traffic over a small preloaded address pool.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 15'($urandom);
      run_req(1'b0, '0, 1'b1, {15'd0, pool[i], 2'd0}, $urandom, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(1, 3);
      a  = {15'($urandom), pool[$urandom_range(0, 7)], 2'($urandom)};
      wa = {15'($urandom), pool[$urandom_range(0, 7)], 2'($urandom)};
      if (kind == 3 && $urandom_range(0, 1) == 1) wa = {a[31:2] ^ 30'h3FFF8000, 2'($urandom)};
      run_req(kind != 2, a, kind != 1, wa, $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
